ins_fetch_q: RTL

Parametrised instruction fetch unit with a decoupling fetch queue. It sits between the instruction cache and the decoder and issues one outstanding IC request at a time. Each returned RV32I/RV32C instruction is pre-decoded to pick the next PC: jal/c.j/c.jal are taken directly and conditional branches follow the predictor. An epoch-style drop state discards stale IC responses after a ROB redirect. Results are buffered in a QDEPTH-entry FIFO that the decoder drains with a valid/ready handshake.

---
 rtl/ins_fetch_q_pkg.sv | 31 +++
 rtl/ins_fetch_q_fifo.sv | 64 ++++++
 rtl/ins_fetch_q.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ins_fetch_q_pkg.sv
// Shared constants and types for the instruction fetch unit:
// pre-decode opcodes/funct3 values, FSM states and control-flow classes.
package ins_fetch_q_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    // RV32C quadrant 1 funct3 values for the control-flow instructions we pre-decode
    localparam logic [1:0] C_Q1   = 2'b01;
    localparam logic [2:0] C_J    = 3'b101;
    localparam logic [2:0] C_JAL  = 3'b001;
    localparam logic [2:0] C_BEQZ = 3'b110;
    localparam logic [2:0] C_BNEZ = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef enum logic [1:0] {
        K_SEQ,
        K_JUMP,
        K_BRANCH
    } ctl_kind_t;

    function automatic logic [2:0] ins_step(input logic [1:0] low);
        return (low == 2'b11) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/ins_fetch_q_fifo.sv
// Fetch queue storage: power-of-two depth FIFO with synchronous flush,
// combinational head read and occupancy count.
module if_fifo
    import ins_fetch_q_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // flush voids any same-cycle push or pop
    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush && ((count < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ins_fetch_q.sv
// Instruction fetch unit: single-outstanding IC requests, next-PC pre-decode
// (jal/c.j/c.jal taken, branches predicted), redirect drop state, fetch queue.
module ins_fetch_q
    import ins_fetch_q_pkg::*;
#(
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       QDEPTH = 4,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              ic_en_o,
    output logic [ADDR_W-1:0] ic_pc_o,
    input  logic              ic_en_i,
    input  logic [31:0]       ic_ins_i,
    output logic [ADDR_W-1:0] bp_pc_o,
    input  logic              bp_br_i,
    input  logic              br_flag_i,
    input  logic              br_abr_i,
    input  logic [ADDR_W-1:0] br_tpc_i,
    input  logic [ADDR_W-1:0] br_cbt_i,
    output logic              bp_en_o,
    output logic              bp_abr_o,
    output logic [ADDR_W-1:0] bp_tpc_o,
    output logic              is_en_o,
    input  logic              is_rdy_i,
    output logic [31:0]       is_ins_o,
    output logic [ADDR_W-1:0] is_pc_o,
    output logic              is_ic_o,
    output logic              is_pbr_o,
    output logic [ADDR_W-1:0] is_ppc_o
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned EW = 32 + ADDR_W + 1 + 1 + ADDR_W;

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc;
    logic              req;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [EW-1:0]     entry_in;
    logic [EW-1:0]     entry_out;

    logic              is_c;
    ctl_kind_t         kind;
    logic [31:0]       imm;
    logic [31:0]       imm_j;
    logic [31:0]       imm_b;
    logic [31:0]       imm_cj;
    logic [31:0]       imm_cb;
    logic              take;
    logic [ADDR_W-1:0] ppc;

    // Pre-decode of the word returning from the IC
    assign is_c   = ic_ins_i[1:0] != 2'b11;
    assign imm_j  = {{12{ic_ins_i[31]}}, ic_ins_i[19:12], ic_ins_i[20],
                     ic_ins_i[30:21], 1'b0};
    assign imm_b  = {{20{ic_ins_i[31]}}, ic_ins_i[7], ic_ins_i[30:25],
                     ic_ins_i[11:8], 1'b0};
    assign imm_cj = {{21{ic_ins_i[12]}}, ic_ins_i[8], ic_ins_i[10:9], ic_ins_i[6],
                     ic_ins_i[7], ic_ins_i[2], ic_ins_i[11], ic_ins_i[5:3], 1'b0};
    assign imm_cb = {{24{ic_ins_i[12]}}, ic_ins_i[6:5], ic_ins_i[2],
                     ic_ins_i[11:10], ic_ins_i[4:3], 1'b0};

    always_comb begin
        kind = K_SEQ;
        imm  = '0;
        if (is_c) begin
            if (ic_ins_i[1:0] == C_Q1) begin
                case (ic_ins_i[15:13])
                    C_J, C_JAL: begin
                        kind = K_JUMP;
                        imm  = imm_cj;
                    end
                    C_BEQZ, C_BNEZ: begin
                        kind = K_BRANCH;
                        imm  = imm_cb;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (ic_ins_i[6:0])
                OPC_JAL: begin
                    kind = K_JUMP;
                    imm  = imm_j;
                end
                OPC_BR: begin
                    kind = K_BRANCH;
                    imm  = imm_b;
                end
                default: ;
            endcase
        end
    end

    assign take = (kind == K_JUMP) || ((kind == K_BRANCH) && bp_br_i);
    assign ppc  = take ? pc + ADDR_W'(signed'(imm))
                       : pc + ADDR_W'(ins_step(ic_ins_i[1:0]));

    // Redirect wins over everything: no request, no push, WAIT falls into DROP
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        push     = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && !br_flag_i && (count < CW'(QDEPTH))) begin
                    req      = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ic_en_i) begin
                    push     = !br_flag_i;
                    state_nx = S_IDLE;
                end else if (br_flag_i) begin
                    state_nx = S_DROP;
                end
            end
            S_DROP: begin
                if (ic_en_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RST_PC;
            ic_en_o <= 1'b0;
        end else begin
            state   <= state_nx;
            ic_en_o <= req;
            if (br_flag_i) begin
                pc <= br_cbt_i;
            end else if (push) begin
                pc <= ppc;
            end
        end
    end

    assign entry_in = {ic_ins_i, pc, is_c, take, ppc};
    assign pop      = is_en_o && is_rdy_i;

    if_fifo #(
        .WIDTH(EW),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(br_flag_i),
        .push (push),
        .din  (entry_in),
        .pop  (pop),
        .dout (entry_out),
        .count(count)
    );

    assign is_en_o = count != '0;
    assign {is_ins_o, is_pc_o, is_ic_o, is_pbr_o, is_ppc_o} = entry_out;

    assign ic_pc_o  = pc;
    assign bp_pc_o  = pc;
    assign bp_en_o  = br_flag_i;
    assign bp_abr_o = br_abr_i;
    assign bp_tpc_o = br_tpc_i;

endmodule
